// File: rtl/mod47_pkg.sv
// Shared constants and types for the {47, 64} residue-number-system blocks.
package mod47_pkg;

  localparam int RW   = 6;    // residue width
  localparam int XW   = 12;   // binary width, 47*64 = 3008 < 4096
  localparam int MOD  = 47;   // odd-channel modulus
  localparam int MOD2 = 94;   // 2*MOD, used by the one-shot double reduction
  localparam int INV  = 36;   // 64^-1 mod 47 (64 = 17 mod 47, 17*36 = 612 = 13*47 + 1)

  typedef logic [RW-1:0] residue_t;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    MUL,
    OUT
  } state_t;

endpackage

// File: rtl/mod47_dbl_add.sv
// One MSB-first step of a serial mod-47 multiply by INV:
// acc_next = (2*acc + (add_inv ? INV : 0)) mod 47, for acc in 0..46.
module mod47_dbl_add
  import mod47_pkg::*;
(
  input  logic [RW-1:0] acc,
  input  logic          add_inv,
  output logic [RW-1:0] acc_next
);

  // 2*46 + 36 = 128 fits in 8 bits and is below 3*47, so at most one
  // subtraction of 47 or 94 brings the sum back into range.
  logic [7:0] t;

  // Double, conditionally add the constant, then reduce once.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here via the
    // full if/else chain); a missing branch would infer a latch.
    t = {1'b0, acc, 1'b0} + (add_inv ? 8'(INV) : 8'd0);
    if (t >= 8'(MOD2)) begin
      acc_next = RW'(t - 8'(MOD2));
    end else if (t >= 8'(MOD)) begin
      acc_next = RW'(t - 8'(MOD));
    end else begin
      acc_next = t[RW-1:0];
    end
  end

endmodule

// File: rtl/mod47_crt_decoder.sv
// Sequential residue-to-binary decoder for the {47, 64} system.
// x = r64 + 64*a1 with a1 = ((r47 - r64) * INV) mod 47, built by a
// one-cycle modular subtract and a six-cycle serial multiply by INV.
// One transaction in flight; accept-to-out_valid latency is 8 cycles.
module mod47_crt_decoder
  import mod47_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] r47,
  input  logic [RW-1:0] r64,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] x,
  output logic          err
);

  state_t   state_q, state_d;
  residue_t r47_q, r64_q;
  residue_t d_q;        // shifted left each MUL step so d_q[RW-1] is the current bit
  residue_t acc_q;      // serial product; holds a1 once MUL completes
  residue_t acc_next;
  residue_t r64m;
  residue_t d_next;
  logic     err_q;
  logic [2:0] step_q;
  logic     accept;
  logic     mul_last;

  assign accept   = in_valid & in_ready;
  assign mul_last = (step_q == 3'd5);

  // Fold r64 into 0..46, then take (r47 - r64m) mod 47. Plain 6-bit
  // wrap-around is fine for the add-47 branch because the result is < 47.
  always_comb begin
    r64m   = (r64_q >= RW'(MOD)) ? r64_q - RW'(MOD) : r64_q;
    d_next = (r47_q >= r64m) ? r47_q - r64m : r47_q + RW'(MOD) - r64m;
  end

  mod47_dbl_add u_dbl_add (
    .acc      (acc_q),
    .add_inv  (d_q[RW-1]),
    .acc_next (acc_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of process ordering.
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SUB;
      SUB:     state_d = MUL;
      MUL:     if (mul_last) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on accept, subtract in SUB, one multiply step per MUL cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r47_q  <= '0;
      r64_q  <= '0;
      err_q  <= 1'b0;
      d_q    <= '0;
      acc_q  <= '0;
      step_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            r47_q <= r47;
            r64_q <= r64;
            err_q <= (r47 >= RW'(MOD));
          end
        end
        SUB: begin
          d_q    <= d_next;
          acc_q  <= '0;
          step_q <= '0;
        end
        MUL: begin
          acc_q  <= acc_next;
          d_q    <= d_q << 1;
          step_q <= step_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state; x is a pure concatenation, zeroed on err.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
    err       = out_valid & err_q;
    x         = (out_valid && !err_q) ? {acc_q, r64_q} : '0;
  end

endmodule
